// File: rtl/parity_frame_pkg.sv
// Shared types and sizing helpers for the parity-protected frame receiver.
package parity_frame_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    PAR  = 2'd2
  } state_e;

  localparam int ERRCNT_W = 8;

  // Bit counter must represent 0..data_w inclusive.
  function automatic int cnt_width(input int data_w);
    return (data_w < 1) ? 1 : $clog2(data_w + 1);
  endfunction

endpackage

// File: rtl/parity_frame_outreg.sv
// Valid/ready holding register for received words; drops a new frame and
// pulses o_ovf when it completes while an unaccepted word is still held.
module parity_frame_outreg #(
  parameter int DATA_W = 4
) (
  input  logic              i_ck,
  input  logic              i_rstn,
  input  logic              i_load,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_perr,
  input  logic              i_ready,
  output logic [DATA_W-1:0] o_data,
  output logic              o_valid,
  output logic              o_perr,
  output logic              o_ovf
);

  logic [DATA_W-1:0] r_data;
  logic              r_valid;
  logic              r_perr;
  logic              r_ovf;
  logic              w_take;
  logic              w_drop;

  // An accept in the same cycle frees the slot, so load back-to-back.
  assign w_take = i_load & (~r_valid | i_ready);
  assign w_drop = i_load & r_valid & ~i_ready;

  always_ff @(posedge i_ck or negedge i_rstn) begin
    if (!i_rstn) begin
      r_data  <= '0;
      r_valid <= 1'b0;
      r_perr  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_ovf <= w_drop;
      if (w_take) begin
        r_data  <= i_data;
        r_perr  <= i_perr;
        r_valid <= 1'b1;
      end else if (r_valid & i_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign o_data  = r_data;
  assign o_valid = r_valid;
  assign o_perr  = r_perr;
  assign o_ovf   = r_ovf;

endmodule

// File: rtl/parity_frame_rx.sv
// Bit-serial parity frame receiver: LSB-first data then one parity bit.
// Define PARITY_FRAME_ERRCNT_EN to add the ERRCLR/ERRCNT parity error counter.
module parity_frame_rx
  import parity_frame_pkg::*;
#(
  parameter int DATA_W     = 4,
  parameter bit ODD_PARITY = 1'b0
) (
  input  logic                CK,
  input  logic                RSTN,
  input  logic                SDI,
  input  logic                SVALID,
  input  logic                SOF,
  output logic [DATA_W-1:0]   DOUT,
  output logic                DVALID,
  input  logic                DREADY,
  output logic                PERR,
  output logic                OVF,
  output logic                ABORT
`ifdef PARITY_FRAME_ERRCNT_EN
  ,
  input  logic                ERRCLR,
  output logic [ERRCNT_W-1:0] ERRCNT
`endif
);

  localparam int               CNT_W = cnt_width(DATA_W);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(DATA_W - 1);

  state_e            r_state;
  state_e            w_state_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic [DATA_W-1:0] r_shift;
  logic [DATA_W-1:0] w_shift_nxt;
  logic [DATA_W-1:0] w_bit;
  logic              r_acc;
  logic              w_acc_nxt;
  logic              r_abort;
  logic              w_abort;
  logic              w_done;
  logic              w_perr;

  always_ff @(posedge CK or negedge RSTN) begin
    if (!RSTN) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // SOF restarts from any state, so it is decoded ahead of the per-state moves.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_shift_nxt = r_shift;
    w_acc_nxt   = r_acc;
    w_abort     = 1'b0;
    w_done      = 1'b0;
    w_bit       = '0;
    w_bit[0]    = SDI;
    if (SVALID) begin
      if (SOF) begin
        w_abort     = (r_state != IDLE);
        w_shift_nxt = w_bit;
        w_acc_nxt   = SDI;
        w_cnt_nxt   = CNT_W'(1);
        w_state_nxt = (DATA_W == 1) ? PAR : DATA;
      end else begin
        unique case (r_state)
          DATA: begin
            w_shift_nxt = r_shift | (w_bit << r_cnt);
            w_acc_nxt   = r_acc ^ SDI;
            w_cnt_nxt   = r_cnt + CNT_W'(1);
            if (r_cnt == LAST) w_state_nxt = PAR;
          end
          PAR: begin
            w_done      = 1'b1;
            w_cnt_nxt   = '0;
            w_state_nxt = IDLE;
          end
          default: ;
        endcase
      end
    end
  end

  assign w_perr = ((r_acc ^ SDI) != ODD_PARITY);

  always_ff @(posedge CK or negedge RSTN) begin
    if (!RSTN) begin
      r_cnt   <= '0;
      r_shift <= '0;
      r_acc   <= 1'b0;
      r_abort <= 1'b0;
    end else begin
      r_cnt   <= w_cnt_nxt;
      r_shift <= w_shift_nxt;
      r_acc   <= w_acc_nxt;
      r_abort <= w_abort;
    end
  end

  assign ABORT = r_abort;

  parity_frame_outreg #(.DATA_W(DATA_W)) u_outreg (
    .i_ck    (CK),
    .i_rstn  (RSTN),
    .i_load  (w_done),
    .i_data  (r_shift),
    .i_perr  (w_perr),
    .i_ready (DREADY),
    .o_data  (DOUT),
    .o_valid (DVALID),
    .o_perr  (PERR),
    .o_ovf   (OVF)
  );

`ifdef PARITY_FRAME_ERRCNT_EN
  logic [ERRCNT_W-1:0] r_errcnt;

  // Dropped frames still count: the error is tallied at completion, not at load.
  always_ff @(posedge CK or negedge RSTN) begin
    if (!RSTN)                               r_errcnt <= '0;
    else if (ERRCLR)                         r_errcnt <= '0;
    else if (w_done & w_perr & ~&r_errcnt)   r_errcnt <= r_errcnt + ERRCNT_W'(1);
  end

  assign ERRCNT = r_errcnt;
`endif

endmodule

// File: tb/tb_parity_frame_rx.sv
// Directed plus randomized bench for parity_frame_rx against a bit-queue reference model.
module tb_parity_frame_rx;

  localparam int DW  = 4;
  localparam bit ODD = 1'b0;

  logic          CK     = 1'b0;
  logic          RSTN   = 1'b0;
  logic          SDI    = 1'b0;
  logic          SVALID = 1'b0;
  logic          SOF    = 1'b0;
  logic          DREADY = 1'b0;
  logic [DW-1:0] DOUT;
  logic          DVALID, PERR, OVF, ABORT;
`ifdef PARITY_FRAME_ERRCNT_EN
  logic          ERRCLR = 1'b0;
  logic [7:0]    ERRCNT;
`endif

  int tests = 0;
  int fails = 0;

  // Reference model state: bits of the frame in flight, and the output slot.
  int            q[$];
  logic [DW-1:0] m_dout;
  logic          m_dvalid, m_perr, m_ovf, m_abort;
  int            m_err;

  always #5 CK = ~CK;

  parity_frame_rx #(.DATA_W(DW), .ODD_PARITY(ODD)) dut (
    .CK     (CK),
    .RSTN   (RSTN),
    .SDI    (SDI),
    .SVALID (SVALID),
    .SOF    (SOF),
    .DOUT   (DOUT),
    .DVALID (DVALID),
    .DREADY (DREADY),
    .PERR   (PERR),
    .OVF    (OVF),
    .ABORT  (ABORT)
`ifdef PARITY_FRAME_ERRCNT_EN
    ,
    .ERRCLR (ERRCLR),
    .ERRCNT (ERRCNT)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_dout = '0; m_dvalid = 1'b0; m_perr = 1'b0; m_ovf = 1'b0; m_abort = 1'b0;
    m_err = 0;
  endtask

  task automatic model(input logic sv, input logic sof, input logic sdi,
                       input logic rdy, input logic clr);
    logic          done;
    logic          pe;
    logic [DW-1:0] d;
    int            ones;
    done = 1'b0; pe = 1'b0; d = '0; ones = 0;
    m_ovf = 1'b0; m_abort = 1'b0;
    if (sv) begin
      if (sof) begin
        if (q.size() > 0) m_abort = 1'b1;
        q.delete();
        q.push_back(int'(sdi));
      end else if (q.size() > 0) begin
        q.push_back(int'(sdi));
        if (q.size() == DW + 1) begin
          done = 1'b1;
          for (int i = 0; i < DW; i++) d[i] = q[i][0];
          foreach (q[i]) ones += q[i];
          pe = ((ones % 2) != int'(ODD));
          q.delete();
        end
      end
    end
    if (done) begin
      if (!m_dvalid || rdy) begin
        m_dvalid = 1'b1; m_dout = d; m_perr = pe;
      end else begin
        m_ovf = 1'b1;
      end
    end else if (m_dvalid && rdy) begin
      m_dvalid = 1'b0;
    end
    if (clr) m_err = 0;
    else if (done && pe && m_err < 255) m_err++;
  endtask

  task automatic check_all();
    chk("dvalid", 32'(DVALID), 32'(m_dvalid));
    chk("dout",   32'(DOUT),   32'(m_dout));
    chk("perr",   32'(PERR),   32'(m_perr));
    chk("ovf",    32'(OVF),    32'(m_ovf));
    chk("abort",  32'(ABORT),  32'(m_abort));
`ifdef PARITY_FRAME_ERRCNT_EN
    chk("errcnt", 32'(ERRCNT), 32'(m_err));
`endif
  endtask

  task automatic step(input logic sv, input logic sof, input logic sdi,
                      input logic rdy, input logic clr = 1'b0);
    SVALID = sv; SOF = sof; SDI = sdi; DREADY = rdy;
`ifdef PARITY_FRAME_ERRCNT_EN
    ERRCLR = clr;
`endif
    @(posedge CK); #1;
    model(sv, sof, sdi, rdy, clr);
    check_all();
  endtask

  task automatic send_frame(input logic [DW-1:0] data, input logic par, input logic rdy,
                            input logic rdy_last, input logic gaps);
    for (int i = 0; i < DW; i++) begin
      if (gaps && i > 0 && $urandom_range(0, 2) == 0)
        step(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rdy);
      step(1'b1, (i == 0), data[i], rdy);
    end
    step(1'b1, 1'b0, par, rdy_last);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    model_reset();
    RSTN = 1'b0;
    repeat (2) @(posedge CK);
    #1;
    check_all();
    #3 RSTN = 1'b1;

    // Good frame 4'hB, even parity bit 1
    send_frame(4'hB, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("f1_dout", 32'(DOUT), 32'hB);
    chk("f1_perr", 32'(PERR), 32'h0);
    chk("f1_dvalid", 32'(DVALID), 32'h1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("f1_accepted", 32'(DVALID), 32'h0);

    // Same data, bad parity
    send_frame(4'hB, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("f2_dout", 32'(DOUT), 32'hB);
    chk("f2_perr", 32'(PERR), 32'h1);
`ifdef PARITY_FRAME_ERRCNT_EN
    chk("f2_errcnt", 32'(ERRCNT), 32'h1);
`endif
    step(1'b0, 1'b0, 1'b0, 1'b1);

    // Back-to-back with consumer stalled: second frame dropped
    send_frame(4'hB, 1'b1, 1'b0, 1'b0, 1'b0);
    send_frame(4'h4, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("b2b_ovf", 32'(OVF), 32'h1);
    chk("b2b_dout", 32'(DOUT), 32'hB);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("b2b_ovf_once", 32'(OVF), 32'h0);

    // Accept and load in the same cycle
    send_frame(4'h4, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("swap_dout", 32'(DOUT), 32'h4);
    chk("swap_dvalid", 32'(DVALID), 32'h1);
    chk("swap_ovf", 32'(OVF), 32'h0);
    step(1'b0, 1'b0, 1'b0, 1'b1);

    // SOF after two data bits restarts with frame 4'h3
    step(1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    chk("abort_pulse", 32'(ABORT), 32'h1);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    chk("abort_once", 32'(ABORT), 32'h0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    chk("abort_dout", 32'(DOUT), 32'h3);
    chk("abort_perr", 32'(PERR), 32'h0);

    // Async reset between data bits 2 and 3, with a word still held
    step(1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    #2 RSTN = 1'b0;
    #1;
    model_reset();
    check_all();
    chk("rst_dout", 32'(DOUT), 32'h0);
    @(negedge CK);
    RSTN = 1'b1;
    send_frame(4'hF, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("post_rst_dout", 32'(DOUT), 32'hF);
    chk("post_rst_perr", 32'(PERR), 32'h0);
    step(1'b0, 1'b0, 1'b0, 1'b1);

    // Randomized whole frames with gaps and random ready
    repeat (40)
      send_frame(DW'($urandom), 1'($urandom), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 1'b1);

    // Free-running random bit stream with sparse SOF
    repeat (600)
      step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 7) == 0),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0),
           1'($urandom_range(0, 31) == 0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/parity_frame_rx.md
Name: parity_frame_rx

Overview:
- Serial receiver/checker for parity-protected frames: DATA_W data bits, LSB first, then one parity bit.
- Deserializes each frame, checks parity with the same XNOR-reduction rule as the library's parity gates, and presents the word through a valid/ready output register.
- Sits between a bit-serial link and word-level logic, as the receiving end of a parity generator/serializer.

Parameters:
- DATA_W, 4, number of data bits per frame (1..32).
- ODD_PARITY, 0, 0 = even parity (XNOR of data and parity bits = 1 means good); 1 = odd parity.

Ports:
- CK  input  1  clock, rising edge.
- RSTN  input  1  asynchronous active-low reset.
- SDI  input  1  serial data bit.
- SVALID  input  1  SDI is sampled on CK edges where SVALID=1.
- SOF  input  1  marks the first data bit of a frame; qualified by SVALID.
- DOUT  output  DATA_W  received data word.
- DVALID  output  1  DOUT/PERR hold a frame.
- DREADY  input  1  consumer accepts the frame when DVALID & DREADY.
- PERR  output  1  parity error for the frame in DOUT; valid while DVALID=1.
- OVF  output  1  one-cycle pulse: a completed frame was dropped because the output was full.
- ABORT  output  1  one-cycle pulse: SOF arrived mid-frame and the frame restarted.

Behaviour:
- Reset (RSTN=0, async): FSM=IDLE, bit counter=0, shift register=0, parity accumulator=0, DOUT=0, DVALID=0, PERR=0, OVF=0, ABORT=0.
- FSM states:
  - IDLE: SVALID & SOF captures SDI as bit 0. Go to DATA, or to PAR if DATA_W=1. SVALID without SOF is ignored.
  - DATA: each SVALID bit shifts in at index = count. After bit DATA_W-1, go to PAR.
  - PAR: the next SVALID bit is the parity bit and completes the frame. Go to IDLE.
- SOF & SVALID while in DATA or PAR: pulse ABORT, discard the partial frame, and treat the bit as bit 0 of a new frame. In PAR, SOF takes priority over parity completion.
- Parity accumulator: XOR of all data bits plus the parity bit. good = (acc == ODD_PARITY). PERR = ~good.
- Latency: DVALID, DOUT and PERR are registered and asserted on the CK edge following the parity bit sample, i.e. visible one cycle after completion.
- Output register:
  - Loads on completion if DVALID=0, or if DVALID=1 & DREADY=1 in the same cycle (simultaneous accept and load: no gap, no overflow).
  - DVALID=1 & DREADY=0 at completion: the new frame is dropped, OVF pulses for one cycle, and the held word stays unchanged.
  - DVALID & DREADY with no completion: DVALID clears next cycle. DOUT retains its last value.
- The receive path runs independently of the output register; back-to-back frames with no idle cycles are supported.
- SVALID gaps inside a frame are allowed; the state holds.
- The bit counter width is clog2(DATA_W+1). The counter never wraps past DATA_W.
- Async reset mid-frame discards all state immediately. The first SOF after reset release starts a clean frame.

Optional Feature:
- Macro: PARITY_FRAME_ERRCNT_EN.
- Defined:
  - Adds output ERRCNT[7:0], a count of completed frames with a parity error, including dropped frames.
  - Saturates at 8'hFF. Reset value 0.
  - Input ERRCLR (1 bit) clears it synchronously and has priority over an increment in the same cycle.
- Undefined: neither port nor counter exists; all other behaviour is identical.

Decomposition:
- Package parity_frame_pkg holds:
  - the state enum (IDLE, DATA, PAR);
  - localparam ERRCNT_W=8;
  - a function computing the counter width from DATA_W.
- One natural sub-module: parity_frame_outreg, the DOUT/PERR/DVALID holding register with its load/accept/overflow logic. The FSM and shift path stay in the top module.

Test Plan:
- DATA_W=4, even: SOF + bits 1,1,0,1, parity 1 -> DOUT=4'hB, PERR=0, DVALID=1 one cycle after the parity bit.
- Same frame with parity bit 0 -> DOUT=4'hB, PERR=1. With PARITY_FRAME_ERRCNT_EN, ERRCNT goes 0 to 1.
- Two back-to-back frames (4'hB then 4'h4 with correct parity), DREADY=0 -> first frame held, OVF pulses once at the second completion, DOUT stays 4'hB.
- DREADY=1 in the same cycle the second frame completes -> DOUT=4'h4 next cycle, DVALID stays 1, no OVF.
- SOF reasserted after two data bits, then a full frame 4'h3 with parity 0 -> ABORT pulses once, DOUT=4'h3, PERR=0.
- RSTN low between data bits 2 and 3 -> all outputs 0 immediately. The next frame 4'hF with parity 0 is received with PERR=0.
